// File: rtl/rotate_sequencer.sv
// Multi-cycle circular rotator: one log-step barrel stage per cycle, valid/ready on both sides.
// Define ROTATE_SEQUENCER_EARLY_EXIT_EN to finish as soon as no higher amount bits remain.
module rotate_sequencer #(
  parameter int unsigned W = 8,
  localparam int unsigned SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [SW-1:0] in_amt,
  input  logic          in_dir,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          busy
);

`ifdef ROTATE_SEQUENCER_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  work_q, work_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] amt_q, amt_d;
  logic [SW-1:0] stage_q, stage_d;
  logic          dir_q, dir_d;
  logic          shift_last;
  logic          accept;

  // Rotate by 2^k using a doubled word so no bits are lost.
  function automatic logic [W-1:0] rot_step(input logic [W-1:0] d, input logic [SW-1:0] k,
                                            input logic right);
    logic [2*W-1:0] dd;
    dd = {d, d};
    if (right) begin
      dd = dd >> (1 << k);
      return dd[W-1:0];
    end else begin
      dd = dd << (1 << k);
      return dd[2*W-1:W];
    end
  endfunction

  assign accept = in_valid && (state_q == StIdle);

  always_comb begin
    if (EarlyExit) begin
      shift_last = ((amt_q >> stage_q) >> 1) == '0;
    end else begin
      shift_last = (stage_q == SW'(SW - 1));
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      work_q     <= '0;
      out_data_q <= '0;
      amt_q      <= '0;
      stage_q    <= '0;
      dir_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      out_data_q <= out_data_d;
      amt_q      <= amt_d;
      stage_q    <= stage_d;
      dir_q      <= dir_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = (EarlyExit && (in_amt == '0)) ? StDone : StShift;
      end
      StShift: begin
        if (shift_last) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    work_d     = work_q;
    out_data_d = out_data_q;
    amt_d      = amt_q;
    stage_d    = stage_q;
    dir_d      = dir_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          work_d  = in_data;
          amt_d   = in_amt;
          dir_d   = in_dir;
          stage_d = '0;
          if (EarlyExit && (in_amt == '0)) out_data_d = in_data;
        end
      end
      StShift: begin
        if (amt_q[stage_q]) work_d = rot_step(work_q, stage_q, dir_q);
        stage_d = stage_q + SW'(1);
        // Result is captured separately so it survives the next acceptance.
        if (shift_last) out_data_d = work_d;
      end
      default: ;
    endcase
  end

  // Output logic.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
  end

  assign out_data = out_data_q;

endmodule

// File: tb/tb_rotate_sequencer.sv
// Directed self-checking bench for rotate_sequencer (W = 8), both latency modes.
module tb_rotate_sequencer;

`ifdef ROTATE_SEQUENCER_EARLY_EXIT_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [2:0] in_amt = '0;
  logic       in_dir = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       busy;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  rotate_sequencer #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs === exp_v) passes++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
  endtask

  // Edges from acceptance (inclusive) until out_valid is seen high.
  function automatic int exp_lat(input logic [2:0] amt);
    if (!Early) return 4;
    if (amt[2]) return 4;
    if (amt[1]) return 3;
    if (amt[0]) return 2;
    return 1;
  endfunction

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic send(input string tag, input logic [7:0] d, input logic [2:0] a, input logic r);
    check_val({tag, "_rdy"}, in_ready, 1);
    in_data  = d;
    in_amt   = a;
    in_dir   = r;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int lat, input logic [7:0] exp_d);
    int n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check_val({tag, "_lat"}, n, lat);
    check_val({tag, "_data"}, out_data, exp_d);
    check_val({tag, "_busy"}, busy, 1);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_val({tag, "_vld_lo"}, out_valid, 0);
    check_val({tag, "_rdy_hi"}, in_ready, 1);
  endtask

  task automatic run(input string tag, input logic [7:0] d, input logic [2:0] a, input logic r,
                     input logic [7:0] exp_d);
    send(tag, d, a, r);
    wait_result(tag, exp_lat(a), exp_d);
    drain(tag);
  endtask

  initial begin
    #12;
    check_val("rst_rdy", in_ready, 1);
    check_val("rst_vld", out_valid, 0);
    check_val("rst_data", out_data, 8'h00);
    check_val("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run("l3", 8'hB4, 3'd3, 1'b0, 8'hA5);
    run("r3", 8'hB4, 3'd3, 1'b1, 8'h96);
    run("l7", 8'h01, 3'd7, 1'b0, 8'h80);
    run("a0", 8'hB4, 3'd0, 1'b0, 8'hB4);
    run("l1", 8'hB4, 3'd1, 1'b0, 8'h69);
    run("r7", 8'hB4, 3'd7, 1'b1, 8'h69);

    // Backpressure: hold result while a new request waits.
    send("bp", 8'hB4, 3'd3, 1'b0);
    wait_result("bp", exp_lat(3'd3), 8'hA5);
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_amt   = 3'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("bp_vld", out_valid, 1);
      check_val("bp_data", out_data, 8'hA5);
      check_val("bp_rdy", in_ready, 0);
    end
    in_valid = 1'b0;
    drain("bp");
    check_val("bp_keep", out_data, 8'hA5);

    // Back-to-back with in_valid held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h0F;
    in_amt    = 3'd4;
    in_dir    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_data = 8'hC3;
    in_amt  = 3'd2;
    in_dir  = 1'b1;
    check_val("b2b_rdy0", in_ready, exp_lat(3'd4) == 1 ? 1 : 0);
    wait_result("b2b1", exp_lat(3'd4), 8'hF0);
    @(posedge clk);
    @(negedge clk);
    check_val("b2b_idle", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    wait_result("b2b2", exp_lat(3'd2), 8'hF0);
    drain("b2b2");

    // Asynchronous reset in the middle of SHIFT.
    send("mid", 8'hB4, 3'd7, 1'b0);
    check_val("mid_busy", busy, 1);
    check_val("mid_vld", out_valid, 0);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_vld", out_valid, 0);
    check_val("arst_data", out_data, 8'h00);
    check_val("arst_rdy", in_ready, 1);
    check_val("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("post", 8'hB4, 3'd3, 1'b0, 8'hA5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
